// File: rtl/coordinate_reader.sv
// -----------------------------------------------------------------------------
// coordinate_reader
//
// Reads N (x,y) pairs back from the coordinate RAMs (XMEM/YMEM) in index order
// and presents them to the path engine as a valid/ready stream.
//
// A small FIFO decouples the one-cycle RAM read latency from downstream
// backpressure. Reads are only issued while (FIFO occupancy + reads in flight)
// is below FIFO_DEPTH. Every issued read therefore already owns a FIFO slot
// when its data returns, and no coordinate is ever dropped or duplicated.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   start                 begin readback (sampled only while idle)
//   abort                 synchronous flush back to idle, no done pulse
//   coord_count           number of pairs to read, latched on an accepted start
//   xmem_address,
//   ymem_address          RAM read address (both always equal)
//   mem_rden              read strobe to both RAMs
//   xmem_q, ymem_q        RAM read data, valid one cycle after mem_rden
//   coord_valid/ready     output stream handshake
//   coord_x/y/index/last  beat payload, taken from the FIFO head
//   busy                  high whenever not idle
//   done                  one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module coordinate_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   coord_count,
    output logic [ADDR_W-1:0] xmem_address,
    output logic [ADDR_W-1:0] ymem_address,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] xmem_q,
    input  logic [DATA_W-1:0] ymem_q,
    output logic              coord_valid,
    input  logic              coord_ready,
    output logic [DATA_W-1:0] coord_x,
    output logic [DATA_W-1:0] coord_y,
    output logic [ADDR_W-1:0] coord_index,
    output logic              coord_last,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 * DATA_W + ADDR_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [ADDR_W:0]   ISSUE_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Readback bookkeeping. issue_ptr is one bit wider than the address so a
    // full 2^ADDR_W readback terminates without wrapping back to index 0.
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   issue_ptr_q;

    // Tag of the read currently in flight; travels with the returning data.
    logic              inflight_q;
    logic [ADDR_W-1:0] rd_idx_q;
    logic              rd_last_q;

    // Output FIFO
    logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
    logic [ENTRY_W-1:0] head;

    logic credit_ok;
    logic issue;
    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    // Credits cover both buffered entries and the read whose data is still
    // on its way back, so the FIFO can never overflow.
    assign credit_ok = (fifo_count_q + CNT_W'(inflight_q)) < DEPTH_C;

    // abort suppresses the strobe so nothing new is launched while flushing.
    assign issue = (state_q == S_FETCH) && !abort && (issue_ptr_q != count_q) && credit_ok;

    // Returning data is only captured if it was not cancelled by an abort.
    assign push = inflight_q && !abort;
    assign pop  = coord_valid && coord_ready && !abort;

    always_comb begin
        fifo_count_d = fifo_count_q;
        if (abort) begin
            fifo_count_d = '0;
        end else if (push && !pop) begin
            fifo_count_d = fifo_count_q + CNT_ONE;
        end else if (pop && !push) begin
            fifo_count_d = fifo_count_q - CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = (coord_count == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (issue && ((issue_ptr_q + ISSUE_ONE) == count_q)) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Using the next occupancy lets DONE follow the final
                    // transfer by exactly one cycle.
                    if ((fifo_count_d == '0) && !inflight_q) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        mem_rden = issue;
    end

    // ------------------------------------------------------------------
    // Issue / in-flight / FIFO pointer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            issue_ptr_q  <= '0;
            inflight_q   <= 1'b0;
            rd_idx_q     <= '0;
            rd_last_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            fifo_count_q <= fifo_count_d;
            inflight_q   <= issue;
            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                // The count is captured only on an accepted start, so changes
                // on coord_count during a readback have no effect.
                if ((state_q == S_IDLE) && start) begin
                    count_q     <= coord_count;
                    issue_ptr_q <= '0;
                end
                if (issue) begin
                    issue_ptr_q <= issue_ptr_q + ISSUE_ONE;
                    rd_idx_q    <= issue_ptr_q[ADDR_W-1:0];
                    rd_last_q   <= (issue_ptr_q == (count_q - ISSUE_ONE));
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
            end
        end
    end

    // FIFO storage has no reset: every read of it is qualified by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {xmem_q, ymem_q, rd_idx_q, rd_last_q};
        end
    end

    assign head = fifo_mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign xmem_address = issue_ptr_q[ADDR_W-1:0];
    assign ymem_address = issue_ptr_q[ADDR_W-1:0];

    assign coord_valid = (fifo_count_q != '0);

    // Payload is forced to zero when nothing is buffered, so uninitialised
    // FIFO storage is never visible on the stream.
    assign coord_x     = coord_valid ? head[ENTRY_W-1 -: DATA_W]          : '0;
    assign coord_y     = coord_valid ? head[ENTRY_W-DATA_W-1 -: DATA_W]   : '0;
    assign coord_index = coord_valid ? head[ADDR_W:1]                     : '0;
    assign coord_last  = coord_valid ? head[0]                            : 1'b0;

endmodule

// File: tb/tb_coordinate_reader.sv
// -----------------------------------------------------------------------------
// Testbench for coordinate_reader.
// RAMs hold x[i]=0x10+i, y[i]=0x80+i. Expected beats, issue cycles and done
// timing are derived from the readback rules with plain arithmetic and
// counters. Inputs change on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_coordinate_reader;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW:0]   coord_count;
    logic [AW-1:0] xmem_address;
    logic [AW-1:0] ymem_address;
    logic          mem_rden;
    logic [DW-1:0] xmem_q;
    logic [DW-1:0] ymem_q;
    logic          coord_valid;
    logic          coord_ready;
    logic [DW-1:0] coord_x;
    logic [DW-1:0] coord_y;
    logic [AW-1:0] coord_index;
    logic          coord_last;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] xram [256];
    logic [DW-1:0] yram [256];

    logic [24:0] head_w;
    assign head_w = {coord_x, coord_y, coord_index, coord_last};

    coordinate_reader #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .coord_count (coord_count),
        .xmem_address(xmem_address),
        .ymem_address(ymem_address),
        .mem_rden    (mem_rden),
        .xmem_q      (xmem_q),
        .ymem_q      (ymem_q),
        .coord_valid (coord_valid),
        .coord_ready (coord_ready),
        .coord_x     (coord_x),
        .coord_y     (coord_y),
        .coord_index (coord_index),
        .coord_last  (coord_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency; garbage on cycles without a read so
    // any mistimed capture shows up as wrong data.
    always @(posedge clk) begin
        if (mem_rden) begin
            xmem_q <= xram[xmem_address];
            ymem_q <= yram[ymem_address];
        end else begin
            xmem_q <= 8'($urandom);
            ymem_q <= 8'($urandom);
        end
    end

    // Expected beat i of an n-entry readback: {x, y, index, last}
    function automatic logic [24:0] exp_beat(input int i, input int n);
        return {8'(16 + i), 8'(128 + i), 8'(i), (i == n - 1)};
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rden, coord_valid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, mem_rden, coord_valid});
        end
        checks++;
        if ({head_w, xmem_address, ymem_address} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {head_w, xmem_address, ymem_address});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rden, coord_valid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=0000", {busy, done, mem_rden, coord_valid});
        end
        $display("reset: outputs checked");
    endtask

    // ------------------------------------------------------------------
    // Full-rate readback with ready held high: reads in cycles 1..n at
    // addresses 0..n-1, beats in cycles 3..n+2, done at n+3 (1 when n=0).
    task automatic test_full_rate(input int n);
        int  done_cyc;
        logic exp_rden;
        logic exp_valid;
        done_cyc = (n == 0) ? 1 : n + 3;
        @(negedge clk);
        coord_ready = 1'b1;
        coord_count = 9'(n);
        start       = 1'b1;
        for (int c = 1; c <= done_cyc + 2; c++) begin
            @(negedge clk);
            start       = 1'b0;
            coord_count = 9'($urandom);   // must be ignored while busy
            exp_rden  = (c >= 1) && (c <= n);
            exp_valid = (c >= 3) && (c <= n + 2);
            checks++;
            if (mem_rden !== exp_rden) begin
                failures++;
                $display("FAIL full_rate_rden n=%0d cycle=%0d got=%b exp=%b", n, c, mem_rden, exp_rden);
            end
            if (exp_rden) begin
                checks++;
                if ((xmem_address !== 8'(c - 1)) || (ymem_address !== 8'(c - 1))) begin
                    failures++;
                    $display("FAIL full_rate_addr n=%0d cycle=%0d got=%h/%h exp=%h", n, c, xmem_address, ymem_address, 8'(c - 1));
                end
            end
            checks++;
            if (coord_valid !== exp_valid) begin
                failures++;
                $display("FAIL full_rate_valid n=%0d cycle=%0d got=%b exp=%b", n, c, coord_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (head_w !== exp_beat(c - 3, n)) begin
                    failures++;
                    $display("FAIL full_rate_beat n=%0d cycle=%0d got=%h exp=%h", n, c, head_w, exp_beat(c - 3, n));
                end
            end
            checks++;
            if (done !== (c == done_cyc)) begin
                failures++;
                $display("FAIL full_rate_done n=%0d cycle=%0d got=%b exp=%b", n, c, done, (c == done_cyc));
            end
            checks++;
            if (busy !== (c <= done_cyc)) begin
                failures++;
                $display("FAIL full_rate_busy n=%0d cycle=%0d got=%b exp=%b", n, c, busy, (c <= done_cyc));
            end
        end
        $display("full_rate: n=%0d readback finished, done expected at cycle %0d", n, done_cyc);
    endtask

    // ------------------------------------------------------------------
    // Random backpressure: in-order beats, stable head while stalled, and
    // never more than DEPTH reads outstanding beyond accepted beats.
    task automatic test_backpressure();
        int          issued;
        int          accepted;
        int          last_xfer;
        bit          stalled;
        bit          seen_done;
        logic [24:0] prev_head;
        issued    = 0;
        accepted  = 0;
        last_xfer = 0;
        stalled   = 1'b0;
        seen_done = 1'b0;
        prev_head = '0;
        @(negedge clk);
        coord_count = 9'd8;
        start       = 1'b1;
        for (int c = 1; c <= 300 && !seen_done; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_rden) begin
                checks++;
                if (xmem_address !== 8'(issued)) begin
                    failures++;
                    $display("FAIL bp_addr cycle=%0d got=%h exp=%h", c, xmem_address, 8'(issued));
                end
                issued++;
            end
            if (stalled) begin
                checks++;
                if ((coord_valid !== 1'b1) || (head_w !== prev_head)) begin
                    failures++;
                    $display("FAIL bp_stable cycle=%0d got=%b/%h exp=1/%h", c, coord_valid, head_w, prev_head);
                end
            end
            checks++;
            if (issued - accepted > DEPTH) begin
                failures++;
                $display("FAIL bp_credit cycle=%0d got=%0d exp<=%0d", c, issued - accepted, DEPTH);
            end
            coord_ready = 1'($urandom_range(0, 1));
            if (done) begin
                seen_done = 1'b1;
                checks++;
                if ((accepted != 8) || (c != last_xfer + 1) || coord_valid) begin
                    failures++;
                    $display("FAIL bp_done cycle=%0d accepted=%0d last_xfer=%0d valid=%b exp=8/%0d/0", c, accepted, last_xfer, coord_valid, c - 1);
                end
            end
            if (coord_valid && coord_ready) begin
                checks++;
                if (head_w !== exp_beat(accepted, 8)) begin
                    failures++;
                    $display("FAIL bp_beat cycle=%0d got=%h exp=%h", c, head_w, exp_beat(accepted, 8));
                end
                $display("bp beat: cycle=%0d x=%h y=%h idx=%0d last=%b", c, coord_x, coord_y, coord_index, coord_last);
                accepted++;
                last_xfer = c;
            end
            stalled   = coord_valid && !coord_ready;
            prev_head = head_w;
        end
        checks++;
        if (!seen_done || issued != 8) begin
            failures++;
            $display("FAIL bp_complete done_seen=%b issued=%0d exp=1/8", seen_done, issued);
        end
        coord_ready = 1'b1;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // abort (with start) while three beats are buffered, then a clean rerun.
    task automatic test_abort();
        int rd_cyc[$];
        int buffered;
        int k;
        bit hit;
        bit fin;
        hit = 1'b0;
        @(negedge clk);
        coord_ready = 1'b0;
        coord_count = 9'd10;
        start       = 1'b1;
        for (int c = 1; c <= 20 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_rden) rd_cyc.push_back(c);
            buffered = 0;
            foreach (rd_cyc[j]) if (rd_cyc[j] <= c - 2) buffered++;
            checks++;
            if (coord_valid !== (buffered > 0)) begin
                failures++;
                $display("FAIL abort_fill_valid cycle=%0d got=%b exp=%b", c, coord_valid, (buffered > 0));
            end
            if (buffered == 3) begin
                abort = 1'b1;
                start = 1'b1;
                hit   = 1'b1;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL abort_setup got=no_fill exp=3_buffered");
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            checks++;
            if ({busy, coord_valid, done, mem_rden} !== 4'b0) begin
                failures++;
                $display("FAIL abort_idle cycle=%0d got=%b exp=0000", c, {busy, coord_valid, done, mem_rden});
            end
        end
        $display("abort: flushed with 3 beats buffered");
        coord_ready = 1'b1;
        coord_count = 9'd10;
        start       = 1'b1;
        k   = 0;
        fin = 1'b0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (coord_valid) begin
                checks++;
                if (head_w !== exp_beat(k, 10)) begin
                    failures++;
                    $display("FAIL abort_rerun_beat cycle=%0d got=%h exp=%h", c, head_w, exp_beat(k, 10));
                end
                $display("rerun beat: cycle=%0d idx=%0d", c, coord_index);
                k++;
            end
            if (done) begin
                fin = 1'b1;
                checks++;
                if (k != 10) begin
                    failures++;
                    $display("FAIL abort_rerun_count got=%0d exp=10", k);
                end
            end
        end
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL abort_rerun_timeout got=no_done exp=done");
        end
    endtask

    // ------------------------------------------------------------------
    // Reset asserted between edges while a readback is active.
    task automatic test_async_reset();
        @(negedge clk);
        coord_ready = 1'b1;
        coord_count = 9'd10;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_rden !== 1'b1) begin
            failures++;
            $display("FAIL async_pre_rden got=%b exp=1", mem_rden);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_rden, coord_valid} !== 4'b0) begin
            failures++;
            $display("FAIL async_ctrl got=%b exp=0000", {busy, done, mem_rden, coord_valid});
        end
        checks++;
        if ({head_w, xmem_address} !== '0) begin
            failures++;
            $display("FAIL async_data got=%h exp=0", {head_w, xmem_address});
        end
        $display("async reset: outputs cleared mid-readback");
        @(negedge clk);
        reset = 1'b0;
        test_full_rate(2);
    endtask

    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            xram[i] = 8'(16 + i);
            yram[i] = 8'(128 + i);
        end
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        coord_ready = 1'b1;
        coord_count = '0;
        test_reset();
        test_full_rate(5);
        test_backpressure();
        test_full_rate(0);
        test_full_rate(256);
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
